// File: rtl/multi_edge_detector_if.sv
// Signal bundle for the multi-channel edge detector: capture inputs,
// per-channel controls and the pulse/status/interrupt results.
interface multi_edge_detector_if #(
  parameter int unsigned NUM_CH = 8,
  parameter int unsigned FILT_W = 4
);
  logic [NUM_CH-1:0]   i_sig_in;
  logic [2*NUM_CH-1:0] i_mode;
  logic [FILT_W-1:0]   i_filt_len;
  logic [NUM_CH-1:0]   i_clr;
  logic [NUM_CH-1:0]   i_irq_en;
  logic [NUM_CH-1:0]   o_pulse;
  logic [NUM_CH-1:0]   o_status;
  logic                o_irq;

  modport master (
    output i_sig_in, i_mode, i_filt_len, i_clr, i_irq_en,
    input  o_pulse, o_status, o_irq
  );

  modport slave (
    input  i_sig_in, i_mode, i_filt_len, i_clr, i_irq_en,
    output o_pulse, o_status, o_irq
  );
endinterface

// File: rtl/multi_edge_detector.sv
// Multi-channel capture-input edge detector: synchroniser, glitch filter,
// mode-selected edge pulse, sticky W1C status and masked level interrupt.
module multi_edge_detector #(
  parameter int unsigned NUM_CH      = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_W      = 4,
  parameter bit          INIT_LEVEL  = 1'b0
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  multi_edge_detector_if.slave  bus
);

  logic [SYNC_STAGES-1:0][NUM_CH-1:0] sync_q, sync_d;
  logic [NUM_CH-1:0][FILT_W-1:0]      cnt_q, cnt_d;
  logic [NUM_CH-1:0]                  filt_q, filt_d;
  logic [NUM_CH-1:0]                  fprev_q;
  logic [NUM_CH-1:0]                  pulse_q, pulse_d;
  logic [NUM_CH-1:0]                  status_q, status_d;
  logic [NUM_CH-1:0]                  sync_out;
  logic [NUM_CH-1:0]                  rise, fall;

  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], bus.i_sig_in};
    sync_out = sync_q[SYNC_STAGES-1];
    rise     = filt_q & ~fprev_q;
    fall     = ~filt_q & fprev_q;
    filt_d   = filt_q;
    cnt_d    = cnt_q;
    pulse_d  = '0;
    for (int unsigned n = 0; n < NUM_CH; n++) begin
      // ">=" lets a lowered filter length release a pending count immediately
      if (sync_out[n] == filt_q[n]) begin
        cnt_d[n] = '0;
      end else if (cnt_q[n] >= bus.i_filt_len) begin
        filt_d[n] = sync_out[n];
        cnt_d[n]  = '0;
      end else begin
        cnt_d[n] = cnt_q[n] + 1'b1;
      end
      unique case (bus.i_mode[2*n +: 2])
        2'b00:   pulse_d[n] = 1'b0;
        2'b01:   pulse_d[n] = rise[n];
        2'b10:   pulse_d[n] = fall[n];
        default: pulse_d[n] = rise[n] | fall[n];
      endcase
    end
    status_d = (status_q & ~bus.i_clr) | pulse_d;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync_q   <= {(SYNC_STAGES*NUM_CH){INIT_LEVEL}};
      filt_q   <= {NUM_CH{INIT_LEVEL}};
      fprev_q  <= {NUM_CH{INIT_LEVEL}};
      cnt_q    <= '0;
      pulse_q  <= '0;
      status_q <= '0;
    end else begin
      sync_q   <= sync_d;
      filt_q   <= filt_d;
      fprev_q  <= filt_q;
      cnt_q    <= cnt_d;
      pulse_q  <= pulse_d;
      status_q <= status_d;
    end
  end

  assign bus.o_pulse  = pulse_q;
  assign bus.o_status = status_q;
  assign bus.o_irq    = |(status_q & bus.i_irq_en);

endmodule

// File: tb/tb_multi_edge_detector.sv
// Scoreboard bench: a per-channel behavioural model predicts pulse/status/irq
// each cycle; a negedge monitor pops predictions and compares with the DUT.
module tb_multi_edge_detector;
  localparam int unsigned NUM_CH      = 8;
  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned FILT_W      = 4;

  typedef struct {
    logic [NUM_CH-1:0] pulse;
    logic [NUM_CH-1:0] status;
    logic              irq;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multi_edge_detector_if #(.NUM_CH(NUM_CH), .FILT_W(FILT_W)) bus ();
  multi_edge_detector_if #(.NUM_CH(NUM_CH), .FILT_W(FILT_W)) bus1 ();

  multi_edge_detector #(
    .NUM_CH(NUM_CH), .SYNC_STAGES(SYNC_STAGES), .FILT_W(FILT_W), .INIT_LEVEL(1'b0)
  ) dut (
    .i_clk(clk), .i_rst(rst), .bus(bus.slave)
  );

  multi_edge_detector #(
    .NUM_CH(NUM_CH), .SYNC_STAGES(SYNC_STAGES), .FILT_W(FILT_W), .INIT_LEVEL(1'b1)
  ) dut1 (
    .i_clk(clk), .i_rst(rst), .bus(bus1.slave)
  );

  int total = 0;
  int bad   = 0;
  exp_t sbq[$];

  // drive values for the next clock edge
  logic                d_rst;
  logic [NUM_CH-1:0]   d_sig, d_clr, d_en;
  logic [2*NUM_CH-1:0] d_mode;
  logic [FILT_W-1:0]   d_len;

  // reference model state
  logic [NUM_CH-1:0] m_pipe[$];
  int                m_run[NUM_CH];
  bit                m_f[NUM_CH];
  bit                m_fp[NUM_CH];
  logic [NUM_CH-1:0] m_pulse, m_status;

  task automatic model_reset();
    m_pipe.delete();
    for (int i = 0; i < SYNC_STAGES; i++) m_pipe.push_back('0);
    for (int n = 0; n < NUM_CH; n++) begin
      m_run[n] = 0;
      m_f[n]   = 1'b0;
      m_fp[n]  = 1'b0;
    end
    m_pulse  = '0;
    m_status = '0;
  endtask

  // one clock edge using the values the DUT sampled at that edge
  task automatic model_step();
    logic [NUM_CH-1:0] s;
    logic [1:0] md;
    bit er, ef, want;
    if (rst) begin
      model_reset();
      return;
    end
    s = m_pipe.pop_front();
    m_pipe.push_back(bus.i_sig_in);
    for (int n = 0; n < NUM_CH; n++) begin
      md   = bus.i_mode[2*n +: 2];
      er   = m_f[n] && !m_fp[n];
      ef   = !m_f[n] && m_fp[n];
      want = (md[0] && er) || (md[1] && ef);
      m_pulse[n]  = want;
      m_status[n] = want || (m_status[n] && !bus.i_clr[n]);
      m_fp[n] = m_f[n];
      // level accepted once it has differed for L+1 consecutive samples
      if (s[n] != m_f[n]) begin
        m_run[n]++;
        if (m_run[n] > int'(bus.i_filt_len)) begin
          m_f[n]   = s[n];
          m_run[n] = 0;
        end
      end else begin
        m_run[n] = 0;
      end
    end
  endtask

  task automatic apply();
    rst            = d_rst;
    bus.i_sig_in   = d_sig;
    bus.i_mode     = d_mode;
    bus.i_filt_len = d_len;
    bus.i_clr      = d_clr;
    bus.i_irq_en   = d_en;
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    model_step();
    #1;
    apply();
    d_clr = '0;
    e.pulse  = m_pulse;
    e.status = m_status;
    e.irq    = |(m_status & d_en);
    sbq.push_back(e);
  endtask

  task automatic ticks(input int k);
    for (int i = 0; i < k; i++) tick();
  endtask

  function automatic logic [2*NUM_CH-1:0] set_mode(input logic [2*NUM_CH-1:0] m,
                                                   input int ch, input logic [1:0] v);
    logic [2*NUM_CH-1:0] r;
    r = m;
    r[2*ch +: 2] = v;
    return r;
  endfunction

  // monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        total++;
        if (bus.o_pulse !== e.pulse) begin
          bad++;
          $display("FAIL pulse t=%0t got %h want %h", $time, bus.o_pulse, e.pulse);
        end
        total++;
        if (bus.o_status !== e.status) begin
          bad++;
          $display("FAIL status t=%0t got %h want %h", $time, bus.o_status, e.status);
        end
        total++;
        if (bus.o_irq !== e.irq) begin
          bad++;
          $display("FAIL irq t=%0t got %b want %b", $time, bus.o_irq, e.irq);
        end
        total++;
        if (bus1.o_pulse !== '0 || bus1.o_status !== '0) begin
          bad++;
          $display("FAIL init_high t=%0t got pulse %h status %h want 00 00",
                   $time, bus1.o_pulse, bus1.o_status);
        end
      end
    end
  end

  initial begin
    bus1.i_sig_in   = '1;
    bus1.i_mode     = '1;
    bus1.i_filt_len = '0;
    bus1.i_clr      = '0;
    bus1.i_irq_en   = '1;

    model_reset();
    d_rst = 1'b1; d_sig = '0; d_clr = '0; d_en = '0; d_mode = '0; d_len = '0;
    apply();
    ticks(3);
    d_rst = 1'b0;
    ticks(3);

    // ch0 rising edge, no filtering
    d_mode = set_mode(d_mode, 0, 2'b01);
    d_sig[0] = 1'b1;
    ticks(8);

    // ch1 falling edge, L=3: short low glitches rejected, 4-cycle low accepted
    d_len = 4'd3;
    d_mode = set_mode(d_mode, 1, 2'b10);
    d_sig[1] = 1'b1; ticks(10);
    d_sig[1] = 1'b0; ticks(1); d_sig[1] = 1'b1; ticks(6);
    d_sig[1] = 1'b0; ticks(3); d_sig[1] = 1'b1; ticks(6);
    d_sig[1] = 1'b0; ticks(4); d_sig[1] = 1'b1; ticks(10);

    // ch2 both edges, square wave period 8, then channel turned off
    d_len = 4'd0;
    d_mode = set_mode(d_mode, 2, 2'b11);
    for (int i = 0; i < 8; i++) begin
      d_sig[2] = ~d_sig[2];
      ticks(4);
    end
    d_mode = set_mode(d_mode, 2, 2'b00);
    for (int i = 0; i < 4; i++) begin
      d_sig[2] = ~d_sig[2];
      ticks(4);
    end

    // ch3 clear colliding with a new pulse, then clear alone
    d_mode = set_mode(d_mode, 3, 2'b11);
    d_sig[3] = 1'b1; ticks(6);
    d_sig[3] = 1'b0; tick(); tick();
    d_clr[3] = 1'b1; tick();
    ticks(4);
    d_clr[3] = 1'b1; tick();
    ticks(3);

    // interrupt masking
    d_clr = '1; tick();
    d_en = 8'h04;
    d_mode = set_mode(d_mode, 5, 2'b11);
    d_sig[5] = ~d_sig[5]; ticks(6);
    d_mode = set_mode(d_mode, 2, 2'b11);
    d_sig[2] = ~d_sig[2]; ticks(6);
    d_clr[2] = 1'b1; tick();
    ticks(3);

    // reset in the middle of a filter interval
    d_len = 4'd5;
    d_mode = '1;
    d_sig[4] = ~d_sig[4]; ticks(5);
    d_rst = 1'b1; tick();
    d_rst = 1'b0; ticks(14);

    // randomized traffic
    for (int cyc = 0; cyc < 2500; cyc++) begin
      if (cyc % 64 == 0) begin
        d_mode = {$urandom, $urandom};
        d_len  = FILT_W'($urandom_range(0, 5));
        d_en   = NUM_CH'($urandom);
      end
      for (int n = 0; n < NUM_CH; n++)
        if ($urandom_range(0, 5) == 0) d_sig[n] = ~d_sig[n];
      d_clr = NUM_CH'($urandom & $urandom & $urandom);
      d_rst = ($urandom_range(0, 299) == 0);
      tick();
    end
    d_rst = 1'b0;
    ticks(2);

    @(negedge clk);
    @(negedge clk);
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL drain got %0d pending want 0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
